// File: rtl/sbuff_drain_ctrl_pkg.sv
// Shared types and constants for the store-buffer drain controller.
package sbuff_drain_ctrl_pkg;

    // Width of a store-buffer entry ID as handed out by dispatch.
    localparam int STORE_BUFFER_ID_WIDTH = 5;

    // Pointers carry one extra wrap bit above the entry index.
    localparam int SBUFF_PTR_W = STORE_BUFFER_ID_WIDTH + 1;

    // Per-entry lifecycle: FREE -> ALLOC -> RDY (AGU written) -> CMT.
    typedef enum logic [1:0] {
        ENT_FREE  = 2'd0,
        ENT_ALLOC = 2'd1,
        ENT_RDY   = 2'd2,
        ENT_CMT   = 2'd3
    } sbuff_ent_e;

    // Drain state machine towards the dcache.
    typedef enum logic [1:0] {
        DRN_IDLE = 2'd0,
        DRN_REQ  = 2'd1,
        DRN_RESP = 2'd2
    } sbuff_drn_e;

    // Number of set bits in a 4-slot valid vector.
    function automatic logic [2:0] slot_cnt(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/sbuff_drain_fsm.sv
// Drain state machine: issues one dcache store request for the head entry,
// waits for the response, then signals the head to retire.
//
// Request handshake: o_req_vld rises only in REQ and stays high with
// addr/data/mask frozen until a cycle where both o_req_vld and i_dc_req_rdy
// are 1; that cycle is the single transfer. The response is a bare valid
// (i_dc_resp_vld) accepted only in RESP; o_drain_done is high in exactly
// that cycle.
import sbuff_drain_ctrl_pkg::*;

module sbuff_drain_fsm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_drain_elig,
    input  logic [ADDR_W-1:0] i_head_addr,
    input  logic [DATA_W-1:0] i_head_data,
    input  logic [MASK_W-1:0] i_head_mask,
    input  logic              i_dc_req_rdy,
    input  logic              i_dc_resp_vld,
    output logic              o_req_vld,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic [DATA_W-1:0] o_req_data,
    output logic [MASK_W-1:0] o_req_mask,
    output logic              o_drain_done,
    output sbuff_drn_e        o_dbg_state
);

    sbuff_drn_e state;

    // State and registered request outputs; the payload is captured once on
    // entry to REQ so it cannot move while the request is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DRN_IDLE;
            o_req_vld  <= 1'b0;
            o_req_addr <= '0;
            o_req_data <= '0;
            o_req_mask <= '0;
        end else begin
            case (state)
                DRN_IDLE: begin
                    if (i_drain_elig) begin
                        state      <= DRN_REQ;
                        o_req_vld  <= 1'b1;
                        o_req_addr <= i_head_addr;
                        o_req_data <= i_head_data;
                        o_req_mask <= i_head_mask;
                    end
                end
                DRN_REQ: begin
                    if (o_req_vld && i_dc_req_rdy) begin
                        state     <= DRN_RESP;
                        o_req_vld <= 1'b0;
                    end
                end
                DRN_RESP: begin
                    if (i_dc_resp_vld) begin
                        state <= DRN_IDLE;
                    end
                end
                default: begin
                    state     <= DRN_IDLE;
                    o_req_vld <= 1'b0;
                end
            endcase
        end
    end

    // Retire pulse coincides with the dcache response.
    assign o_drain_done = (state == DRN_RESP) && i_dc_resp_vld;
    assign o_dbg_state  = state;

endmodule

// File: rtl/sbuff_drain_ctrl.sv
// Store-buffer entry tracking and in-order drain to the dcache. Entries are
// allocated by dispatch, filled by the AGU, committed by the ROB and then
// drained one at a time; each drained store returns one dispatch credit.
import sbuff_drain_ctrl_pkg::*;

module sbuff_drain_ctrl #(
    parameter int DEPTH  = 32,
    parameter int ID_W   = STORE_BUFFER_ID_WIDTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_csr_trap_flush,
    input  logic              i_exu_mis_flush,
    input  logic              i_rob_mis_st_vld,
    input  logic [ID_W-1:0]   i_rob_mis_st_id,
    input  logic [3:0]        i_dsp_stq_req_vld,
    input  logic [ID_W-1:0]   i_dsp_stq_req_dsp_id,
    input  logic              i_agu_st_vld,
    input  logic [ID_W-1:0]   i_agu_st_id,
    input  logic [ADDR_W-1:0] i_agu_st_addr,
    input  logic [DATA_W-1:0] i_agu_st_data,
    input  logic [MASK_W-1:0] i_agu_st_mask,
    input  logic [3:0]        i_rob_st_cmt_vld,
    output logic              o_dc_st_req_vld,
    input  logic              i_dc_st_req_rdy,
    output logic [ADDR_W-1:0] o_dc_st_req_addr,
    output logic [DATA_W-1:0] o_dc_st_req_data,
    output logic [MASK_W-1:0] o_dc_st_req_mask,
    input  logic              i_dc_st_resp_vld,
    output logic              o_exu_dsp_s_ret,
    output logic              o_sbuff_idle,
    output logic              o_sbuff_cmt_empty
);

    localparam int PW = ID_W + 1;

    // Pointers: head = oldest live entry, cmt = first uncommitted, tail = next free.
    logic [PW-1:0]     head_ptr;
    logic [PW-1:0]     cmt_ptr;
    logic [PW-1:0]     tail_ptr;
    logic [ID_W-1:0]   head_idx;

    sbuff_ent_e        ent_state     [DEPTH];
    sbuff_ent_e        ent_state_nxt [DEPTH];
    // Set while an entry is committed but its AGU write has not landed.
    logic [DEPTH-1:0]  ent_cflag;
    logic [DEPTH-1:0]  ent_cflag_nxt;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [MASK_W-1:0] ent_mask [DEPTH];

    logic [2:0]        alloc_cnt;
    logic [2:0]        cmt_cnt;
    logic              mis_flush;
    logic [PW-1:0]     rb_ptr;
    logic [PW-1:0]     flush_len;
    logic [DEPTH-1:0]  alloc_hit;
    logic [DEPTH-1:0]  cmt_hit;
    logic [DEPTH-1:0]  flush_hit;
    logic [DEPTH-1:0]  wr_hit;
    logic [DEPTH-1:0]  free_hit;

    logic              drain_elig;
    logic              drain_done;
    sbuff_drn_e        drn_state;
    logic              fsm_idle;

    assign head_idx  = head_ptr[ID_W-1:0];
    assign alloc_cnt = slot_cnt(i_dsp_stq_req_vld);
    assign cmt_cnt   = slot_cnt(i_rob_st_cmt_vld);
    assign mis_flush = i_exu_mis_flush && i_rob_mis_st_vld;

    // The rollback point is measured from cmt so that a full buffer with a
    // rollback to the first uncommitted ID discards every uncommitted entry.
    assign rb_ptr    = cmt_ptr + {1'b0, i_rob_mis_st_id - cmt_ptr[ID_W-1:0]};
    assign flush_len = tail_ptr - rb_ptr;

    // Per-entry event decode: each range test is a modular distance from the
    // range start compared against the range length.
    always_comb begin
        alloc_hit = '0;
        cmt_hit   = '0;
        flush_hit = '0;
        wr_hit    = '0;
        free_hit  = '0;
        for (int e = 0; e < DEPTH; e++) begin
            flush_hit[e] = mis_flush &&
                           ({1'b0, ID_W'(e) - rb_ptr[ID_W-1:0]} < flush_len);
            alloc_hit[e] = !mis_flush &&
                           ({1'b0, ID_W'(e) - i_dsp_stq_req_dsp_id} < PW'(alloc_cnt));
            cmt_hit[e]   = ({1'b0, ID_W'(e) - cmt_ptr[ID_W-1:0]} < PW'(cmt_cnt));
            wr_hit[e]    = i_agu_st_vld && !i_csr_trap_flush && !flush_hit[e] &&
                           (i_agu_st_id == ID_W'(e)) && (ent_state[e] != ENT_FREE);
            free_hit[e]  = drain_done && (head_idx == ID_W'(e));
        end
    end

    // Next entry state: trap/rollback clear first, then allocation, then
    // retirement, then write/commit progress on live entries.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            ent_state_nxt[e] = ent_state[e];
            ent_cflag_nxt[e] = ent_cflag[e];
            if (i_csr_trap_flush || flush_hit[e]) begin
                ent_state_nxt[e] = ENT_FREE;
                ent_cflag_nxt[e] = 1'b0;
            end else if (alloc_hit[e]) begin
                ent_state_nxt[e] = ENT_ALLOC;
                ent_cflag_nxt[e] = 1'b0;
            end else if (free_hit[e]) begin
                ent_state_nxt[e] = ENT_FREE;
                ent_cflag_nxt[e] = 1'b0;
            end else if (ent_state[e] == ENT_ALLOC) begin
                if (wr_hit[e]) begin
                    ent_state_nxt[e] = (ent_cflag[e] || cmt_hit[e]) ? ENT_CMT : ENT_RDY;
                    ent_cflag_nxt[e] = 1'b0;
                end else begin
                    ent_cflag_nxt[e] = ent_cflag[e] || cmt_hit[e];
                end
            end else if (ent_state[e] == ENT_RDY && cmt_hit[e]) begin
                ent_state_nxt[e] = ENT_CMT;
            end
        end
    end

    // Entry state and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                ent_state[e] <= ENT_FREE;
            end
            ent_cflag <= '0;
            head_ptr  <= '0;
            cmt_ptr   <= '0;
            tail_ptr  <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                ent_state[e] <= ent_state_nxt[e];
            end
            ent_cflag <= ent_cflag_nxt;
            if (i_csr_trap_flush) begin
                head_ptr <= '0;
                cmt_ptr  <= '0;
                tail_ptr <= '0;
            end else begin
                if (drain_done) begin
                    head_ptr <= head_ptr + PW'(1);
                end
                cmt_ptr  <= cmt_ptr + PW'(cmt_cnt);
                tail_ptr <= mis_flush ? rb_ptr : tail_ptr + PW'(alloc_cnt);
            end
        end
    end

    // Store payload array; only accepted AGU writes update it.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (wr_hit[e]) begin
                ent_addr[e] <= i_agu_st_addr;
                ent_data[e] <= i_agu_st_data;
                ent_mask[e] <= i_agu_st_mask;
            end
        end
    end

    // The head may drain once it is committed and its data has landed.
    assign drain_elig = (head_ptr != cmt_ptr) && (ent_state[head_idx] == ENT_CMT);

    sbuff_drain_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MASK_W (MASK_W)
    ) u_drain_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_drain_elig  (drain_elig),
        .i_head_addr   (ent_addr[head_idx]),
        .i_head_data   (ent_data[head_idx]),
        .i_head_mask   (ent_mask[head_idx]),
        .i_dc_req_rdy  (i_dc_st_req_rdy),
        .i_dc_resp_vld (i_dc_st_resp_vld),
        .o_req_vld     (o_dc_st_req_vld),
        .o_req_addr    (o_dc_st_req_addr),
        .o_req_data    (o_dc_st_req_data),
        .o_req_mask    (o_dc_st_req_mask),
        .o_drain_done  (drain_done),
        .o_dbg_state   (drn_state)
    );

    assign fsm_idle          = (drn_state == DRN_IDLE);
    assign o_exu_dsp_s_ret   = drain_done;
    assign o_sbuff_cmt_empty = (head_ptr == cmt_ptr) && fsm_idle;
    assign o_sbuff_idle      = (head_ptr == tail_ptr) && fsm_idle;

endmodule

// File: tb/tb_sbuff_drain_ctrl.sv
// Bench for sbuff_drain_ctrl: directed scenarios plus a randomized overlapped
// stream, checked against a pointer/queue model of the store buffer.
module tb_sbuff_drain_ctrl;

    localparam int NE    = 32;
    localparam int PKT_W = 32 + 64 + 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_csr_trap_flush;
    logic        i_exu_mis_flush;
    logic        i_rob_mis_st_vld;
    logic [4:0]  i_rob_mis_st_id;
    logic [3:0]  i_dsp_stq_req_vld;
    logic [4:0]  i_dsp_stq_req_dsp_id;
    logic        i_agu_st_vld;
    logic [4:0]  i_agu_st_id;
    logic [31:0] i_agu_st_addr;
    logic [63:0] i_agu_st_data;
    logic [7:0]  i_agu_st_mask;
    logic [3:0]  i_rob_st_cmt_vld;
    logic        o_dc_st_req_vld;
    logic        i_dc_st_req_rdy;
    logic [31:0] o_dc_st_req_addr;
    logic [63:0] o_dc_st_req_data;
    logic [7:0]  o_dc_st_req_mask;
    logic        i_dc_st_resp_vld;
    logic        o_exu_dsp_s_ret;
    logic        o_sbuff_idle;
    logic        o_sbuff_cmt_empty;

    sbuff_drain_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_csr_trap_flush     (i_csr_trap_flush),
        .i_exu_mis_flush      (i_exu_mis_flush),
        .i_rob_mis_st_vld     (i_rob_mis_st_vld),
        .i_rob_mis_st_id      (i_rob_mis_st_id),
        .i_dsp_stq_req_vld    (i_dsp_stq_req_vld),
        .i_dsp_stq_req_dsp_id (i_dsp_stq_req_dsp_id),
        .i_agu_st_vld         (i_agu_st_vld),
        .i_agu_st_id          (i_agu_st_id),
        .i_agu_st_addr        (i_agu_st_addr),
        .i_agu_st_data        (i_agu_st_data),
        .i_agu_st_mask        (i_agu_st_mask),
        .i_rob_st_cmt_vld     (i_rob_st_cmt_vld),
        .o_dc_st_req_vld      (o_dc_st_req_vld),
        .i_dc_st_req_rdy      (i_dc_st_req_rdy),
        .o_dc_st_req_addr     (o_dc_st_req_addr),
        .o_dc_st_req_data     (o_dc_st_req_data),
        .o_dc_st_req_mask     (o_dc_st_req_mask),
        .i_dc_st_resp_vld     (i_dc_st_resp_vld),
        .o_exu_dsp_s_ret      (o_exu_dsp_s_ret),
        .o_sbuff_idle         (o_sbuff_idle),
        .o_sbuff_cmt_empty    (o_sbuff_cmt_empty)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- model and scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int m_head, m_cmt, m_tail, m_push;   // unbounded store sequence numbers
    bit m_alloc   [NE];
    bit m_written [NE];
    logic [PKT_W-1:0] m_pkt [NE];
    logic [PKT_W-1:0] exp_q [$];         // committed+written stores, drain order
    bit outstanding = 0;                 // request accepted, response pending
    int rdy_mode = 2;                    // 0 random, 1 never, 2 always
    int resp_pct = 60;
    int n_ret = 0;                       // observed s_ret pulses

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % NE) + NE) % NE;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_alloc[i]   = 0;
            m_written[i] = 0;
        end
        m_head = 0; m_cmt = 0; m_tail = 0; m_push = 0;
    endtask

    // One clock cycle: drive dcache side, monitor, advance model.
    task automatic tick();
        bit resp_drv;
        bit hs;
        int rb;
        bit mis;
        resp_drv = outstanding && ($urandom_range(0, 99) < resp_pct);
        i_dc_st_resp_vld = resp_drv;
        case (rdy_mode)
            0:       i_dc_st_req_rdy = 1'($urandom_range(0, 1));
            1:       i_dc_st_req_rdy = 1'b0;
            default: i_dc_st_req_rdy = 1'b1;
        endcase
        #1;
        hs = 0;
        check("s_ret", o_exu_dsp_s_ret, resp_drv);
        if (o_exu_dsp_s_ret) n_ret++;
        if (o_dc_st_req_vld) begin
            if (exp_q.size() == 0 || outstanding) begin
                check("req_unexpected", o_dc_st_req_vld, 1'b0);
            end else begin
                check("req_pkt", {o_dc_st_req_addr, o_dc_st_req_data, o_dc_st_req_mask}, exp_q[0]);
                if (i_dc_st_req_rdy) begin
                    void'(exp_q.pop_front());
                    hs = 1;
                end
            end
        end
        if (resp_drv) begin
            outstanding = 0;
            m_alloc[wrap(m_head)]   = 0;
            m_written[wrap(m_head)] = 0;
            m_head++;
        end
        if (hs) outstanding = 1;

        if (i_csr_trap_flush) begin
            model_reset();
        end else begin
            mis = i_exu_mis_flush && i_rob_mis_st_vld;
            rb  = m_tail;
            if (mis) rb = m_cmt + wrap(int'(i_rob_mis_st_id) - m_cmt);
            if (i_agu_st_vld && m_alloc[i_agu_st_id] &&
                !(mis && wrap(int'(i_agu_st_id) - rb) < (m_tail - rb))) begin
                m_written[i_agu_st_id] = 1;
                m_pkt[i_agu_st_id] = {i_agu_st_addr, i_agu_st_data, i_agu_st_mask};
            end
            if (mis) begin
                for (int p = rb; p < m_tail; p++) begin
                    m_alloc[wrap(p)]   = 0;
                    m_written[wrap(p)] = 0;
                end
                m_tail = rb;
            end else begin
                for (int k = 0; k < $countones(i_dsp_stq_req_vld); k++) begin
                    m_alloc[wrap(m_tail + k)]   = 1;
                    m_written[wrap(m_tail + k)] = 0;
                end
                m_tail += $countones(i_dsp_stq_req_vld);
            end
            m_cmt += $countones(i_rob_st_cmt_vld);
            while (m_push < m_cmt && m_written[wrap(m_push)]) begin
                exp_q.push_back(m_pkt[wrap(m_push)]);
                m_push++;
            end
        end

        @(posedge clk);
        @(negedge clk);
        i_csr_trap_flush  = 0;
        i_exu_mis_flush   = 0;
        i_rob_mis_st_vld  = 0;
        i_dsp_stq_req_vld = 0;
        i_agu_st_vld      = 0;
        i_rob_st_cmt_vld  = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_alloc(input int n);
        i_dsp_stq_req_vld    = 4'((1 << n) - 1);
        i_dsp_stq_req_dsp_id = 5'(wrap(m_tail));
    endtask

    task automatic drive_write(input int id, input logic [31:0] addr);
        i_agu_st_vld  = 1;
        i_agu_st_id   = 5'(id);
        i_agu_st_addr = addr;
        i_agu_st_data = {$urandom, $urandom};
        i_agu_st_mask = 8'($urandom_range(1, 255));
    endtask

    task automatic drive_commit(input int n);
        i_rob_st_cmt_vld = 4'((1 << n) - 1);
    endtask

    task automatic drain_wait(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || outstanding) && n < budget) begin
            tick();
            n++;
        end
        check(tag, n < budget, 1'b1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ret0;
        int n;
        int na, nc, j, cap, allocated, base;
        int wr_pend_q [$];

        rst_n = 0;
        i_csr_trap_flush = 0; i_exu_mis_flush = 0; i_rob_mis_st_vld = 0;
        i_rob_mis_st_id = 0; i_dsp_stq_req_vld = 0; i_dsp_stq_req_dsp_id = 0;
        i_agu_st_vld = 0; i_agu_st_id = 0; i_agu_st_addr = 0; i_agu_st_data = 0;
        i_agu_st_mask = 0; i_rob_st_cmt_vld = 0; i_dc_st_req_rdy = 0; i_dc_st_resp_vld = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req_vld", o_dc_st_req_vld, 1'b0);
        check("rst_s_ret", o_exu_dsp_s_ret, 1'b0);
        check("rst_idle", o_sbuff_idle, 1'b1);
        check("rst_cmt_empty", o_sbuff_cmt_empty, 1'b1);
        check("rst_req_pkt", {o_dc_st_req_addr, o_dc_st_req_data, o_dc_st_req_mask}, '0);
        rst_n = 1;

        // Quiet after reset.
        for (int c = 0; c < 20; c++) begin
            tick();
            check("quiet_req_vld", o_dc_st_req_vld, 1'b0);
            check("quiet_idle", o_sbuff_idle, 1'b1);
            check("quiet_cmt_empty", o_sbuff_cmt_empty, 1'b1);
        end

        // Alloc 4, write 4, commit 2: two in-order drains, two entries remain.
        drive_alloc(4); tick();
        for (int i = 0; i < 4; i++) begin
            drive_write(i, 32'h1000 + 32'(8 * i)); tick();
        end
        ret0 = n_ret;
        drive_commit(2); tick();
        drain_wait("t2_drain", 100);
        check("t2_ret_cnt", n_ret - ret0, 2);
        check("t2_idle", o_sbuff_idle, 1'b0);
        check("t2_cmt_empty", o_sbuff_cmt_empty, 1'b1);

        // Back-pressure: request held stable while rdy=0.
        rdy_mode = 1;
        ret0 = n_ret;
        drive_commit(1); tick();
        n = 0;
        while (!o_dc_st_req_vld && n < 20) begin tick(); n++; end
        check("t3_req_seen", o_dc_st_req_vld, 1'b1);
        repeat (5) tick();
        check("t3_req_held", o_dc_st_req_vld, 1'b1);
        check("t3_no_ret", n_ret - ret0, 0);
        rdy_mode = 2;
        drain_wait("t3_drain", 100);
        check("t3_ret_cnt", n_ret - ret0, 1);
        drive_commit(1); tick();
        drain_wait("t3b_drain", 100);
        check("t3_idle", o_sbuff_idle, 1'b1);

        // Trap flush with three uncommitted entries.
        drive_alloc(3); tick();
        tick();
        check("t6_busy", o_sbuff_idle, 1'b0);
        i_csr_trap_flush = 1; tick();
        check("t6_idle", o_sbuff_idle, 1'b1);
        check("t6_cmt_empty", o_sbuff_cmt_empty, 1'b1);
        ret0 = n_ret;
        drive_alloc(1); tick();
        drive_write(0, 32'h2000); tick();
        drive_commit(1); tick();
        drain_wait("t6_drain", 100);
        check("t6_ret_cnt", n_ret - ret0, 1);
        i_csr_trap_flush = 1; tick();

        // Mispredict rollback with a same-cycle write to a discarded ID.
        rdy_mode = 0;
        drive_alloc(4); tick();
        drive_alloc(2); drive_write(0, 32'h3000); tick();
        drive_write(1, 32'h3008); tick();
        drive_write(2, 32'h3010); tick();
        drive_write(3, 32'h3018); tick();
        drive_write(5, 32'h3028); tick();
        drive_commit(2); tick();
        i_exu_mis_flush = 1; i_rob_mis_st_vld = 1; i_rob_mis_st_id = 5'd3;
        drive_write(4, 32'h3020); tick();
        drain_wait("t4_drain01", 200);
        check("t4_idle", o_sbuff_idle, 1'b0);
        drive_alloc(1); tick();
        drive_write(3, 32'h3118); tick();
        drive_commit(2); tick();
        drain_wait("t4_drain23", 200);
        check("t4_idle_after", o_sbuff_idle, 1'b1);
        // Commit before write: must wait for the write, then drain.
        drive_alloc(1); tick();
        drive_commit(1); tick();
        repeat (8) tick();
        check("t4_cmt_wait", o_sbuff_cmt_empty, 1'b0);
        drive_write(4, 32'h3220); tick();
        drain_wait("t4_drain4", 200);
        check("t4_final_idle", o_sbuff_idle, 1'b1);

        // Randomized overlapped stream of 40 stores (wraps the IDs).
        rdy_mode = 0;
        resp_pct = 50;
        ret0 = n_ret;
        allocated = 0;
        n = 0;
        while (!(allocated == 40 && exp_q.size() == 0 && !outstanding && m_head == m_tail)
               && n < 3000) begin
            cap = NE - (m_tail - m_head);
            na = $urandom_range(0, 4);
            if (na > cap) na = cap;
            if (na > 40 - allocated) na = 40 - allocated;
            base = m_tail;
            if (na > 0) drive_alloc(na);
            if (wr_pend_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                j = $urandom_range(0, wr_pend_q.size() - 1);
                drive_write(wr_pend_q[j], $urandom);
                wr_pend_q.delete(j);
            end
            nc = $urandom_range(0, 4);
            if (nc > m_tail - m_cmt) nc = m_tail - m_cmt;
            if (nc > 0) drive_commit(nc);
            tick();
            for (int k = 0; k < na; k++) wr_pend_q.push_back(wrap(base + k));
            allocated += na;
            n++;
        end
        check("t5_budget", n < 3000, 1'b1);
        check("t5_ret_cnt", n_ret - ret0, 40);
        tick();
        check("t5_idle", o_sbuff_idle, 1'b1);
        check("t5_cmt_empty", o_sbuff_cmt_empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if something hangs.
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sbuff_drain_ctrl.md
Name: sbuff_drain_ctrl

Overview:
- Store-buffer side of the dispatch store-ID protocol. Dispatch hands out store-buffer IDs in order; this block is the consumer of those IDs.
- Tracks per-entry state: allocated, then written by AGU, then committed by ROB, then drained.
- Drains committed stores in order to the dcache through a valid/ready request plus a response handshake.
- Pulses `o_exu_dsp_s_ret` once per drained store, which returns the credit to the dispatch allocator.

Parameters:
- DEPTH, 32, number of store-buffer entries (power of 2).
- ID_W, 5, entry ID width; equals `STORE_BUFFER_ID_WIDTH`.
- ADDR_W, 32, store address width.
- DATA_W, 64, store data width.
- MASK_W, 8, byte-mask width (DATA_W/8).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_csr_trap_flush  in  1  clear all non-committed entries; reset pointers
- i_exu_mis_flush  in  1  mispredict/ld-st flush
- i_rob_mis_st_vld  in  1  flush carries a store rollback point
- i_rob_mis_st_id  in  ID_W  first ID to discard
- i_dsp_stq_req_vld  in  4  per-slot allocation valid, packed in order
- i_dsp_stq_req_dsp_id  in  ID_W  ID of first allocated slot
- i_agu_st_vld  in  1  address/data write
- i_agu_st_id  in  ID_W  target entry
- i_agu_st_addr  in  ADDR_W  store address
- i_agu_st_data  in  DATA_W  store data
- i_agu_st_mask  in  MASK_W  byte mask
- i_rob_st_cmt_vld  in  4  per-slot commit valid (count = popcount)
- o_dc_st_req_vld  out  1  drain request
- i_dc_st_req_rdy  in  1  dcache accepts request
- o_dc_st_req_addr  out  ADDR_W  drain address
- o_dc_st_req_data  out  DATA_W  drain data
- o_dc_st_req_mask  out  MASK_W  drain mask
- i_dc_st_resp_vld  in  1  store completed
- o_exu_dsp_s_ret  out  1  one-cycle credit return
- o_sbuff_idle  out  1  no allocated entries and FSM idle
- o_sbuff_cmt_empty  out  1  no committed-undrained entries

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset state:
  - all entries FREE; head, commit and tail pointers = 0; FSM = IDLE.
  - `o_dc_st_req_vld`, addr, data, mask and `o_exu_dsp_s_ret` = 0.
  - `o_sbuff_idle` = 1 and `o_sbuff_cmt_empty` = 1.
- Pointers: head, cmt and tail are ID_W+1 bits; the MSB is the wrap bit and the entry index is the low ID_W bits. All arithmetic is modulo 2^(ID_W+1).
- Entry states: FREE → ALLOC → RDY (AGU written) → CMT. An entry that is committed before its AGU write is held as ALLOC+cmt flag and becomes CMT when the write lands.
- Allocation:
  - Entries `dsp_id` to `dsp_id + popcount(req_vld) - 1` become ALLOC; tail advances by the popcount.
  - `dsp_id` must equal tail[ID_W-1:0]. A mismatch is a bench assertion, and the RTL ignores it.
  - Allocating beyond DEPTH outstanding is an assertion error.
- AGU write: addr/data/mask stored and entry moves to RDY. A write to a FREE entry is dropped.
- Commit: cmt advances by popcount(`i_rob_st_cmt_vld`). Entries become drain-eligible in the next cycle. Committing past tail is an assertion error.
- Drain FSM:
  - IDLE → REQ when head != cmt and the head entry is CMT with data written. Addr, data and mask are registered from the head entry on this transition.
  - REQ: `o_dc_st_req_vld` = 1 and outputs are held stable. On vld & rdy, go to RESP.
  - RESP: on `i_dc_st_resp_vld`, pulse `o_exu_dsp_s_ret` the same cycle, free the head entry, head++, and return to IDLE.
  - Minimum turnaround is 3 cycles per store.
- Mispredict flush: when `i_exu_mis_flush & i_rob_mis_st_vld`:
  - entries from `mis_st_id` to tail-1 become FREE and tail := the rollback pointer.
  - Flush wins over a same-cycle allocation (dropped) and over an AGU write to a flushed ID (dropped).
  - Committed entries are never flushed; the ROB guarantees cmt ≤ `mis_st_id`.
- Trap flush: legal only when `o_sbuff_cmt_empty` = 1 (so FSM is IDLE). All entries become FREE and head, cmt, tail := 0. Trap flush has priority over every other same-cycle event.
- Commit, allocation, AGU write and drain may all occur in one cycle and are independent.
- Status outputs:
  - `o_sbuff_cmt_empty` = (head == cmt) & FSM IDLE.
  - `o_sbuff_idle` = (head == tail) & FSM IDLE.
- Reset asserted mid-drain: immediate return to the reset state; an outstanding dcache response is discarded by the environment.

Decomposition:
- Shared package:
  - `STORE_BUFFER_ID_WIDTH` (existing).
  - Entry-state encodings FREE/ALLOC/RDY/CMT (2 bits).
  - Drain-FSM encodings IDLE/REQ/RESP (2 bits).
  - Pointer width constant ID_W+1.
- One sub-module, `sbuff_drain_fsm`: holds the FSM and request output registers, takes the head entry fields and the eligibility signal, and produces the head-increment / `s_ret` pulse.

Test Plan:
- Reset → req_vld=0, s_ret=0, idle=1, cmt_empty=1; after release with no stimulus, nothing toggles for 20 cycles.
- Alloc 4'b1111 with dsp_id 0; AGU writes ids 0-3 with addr 0x1000+8·i; commit 4'b0011 → requests at 0x1000 then 0x1008 in order, two s_ret pulses, ids 2-3 remain, idle=0.
- Request in REQ with rdy=0 for 5 cycles → req_vld held with addr/data/mask stable, no s_ret; rdy=1 → one handshake, then s_ret pulses on the response.
- Alloc ids 0-5, commit 2, mis flush at id 3 with a same-cycle AGU write to id 4 → ids 3-5 FREE and write dropped; next alloc of 1 at dsp_id 3 accepted; ids 0,1 drain normally.
- Stream 40 stores with alloc/commit/drain overlapped → IDs wrap 31→0, drain order matches allocation order, exactly 40 s_ret pulses, idle=1 at end.
- 3 entries allocated and uncommitted, then trap flush → all FREE; next allocation at dsp_id 0 accepted; no dcache request issued.
